// File: rtl/pwm_deadtime.sv
// Complementary gate-drive stage: turns one PWM waveform into a high-side /
// low-side pair with programmable dead time on each edge, a latching fault
// shutdown and a small register bus for configuration.
module pwm_deadtime (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        re_i,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] rdata_o,
    input  logic        pwm_i,
    input  logic        fault_i,
    output logic        hs_o,
    output logic        ls_o,
    output logic        oe_o
);

    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_DT_RISE = 8'h04;
    localparam logic [7:0] ADDR_DT_FALL = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h0C;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LS_ON = 3'd1,
        ST_DT_R  = 3'd2,
        ST_HS_ON = 3'd3,
        ST_DT_F  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    genvar gi;

    // ------------------------------------------------------------------
    // Input synchronizers: bit 0 = pwm, bit 1 = fault
    // ------------------------------------------------------------------
    logic [1:0] async_in;
    logic [1:0] meta_reg;
    logic [1:0] sync_reg;
    logic       pwm_s;
    logic       fault_s;

    assign async_in = {fault_i, pwm_i};
    assign pwm_s    = sync_reg[0];
    assign fault_s  = sync_reg[1];

    // Two-flop synchronizer for both asynchronous inputs, cleared by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_reg <= 2'b00;
            sync_reg <= 2'b00;
        end else begin
            meta_reg <= async_in;
            sync_reg <= meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Register bus
    // ------------------------------------------------------------------
    logic        wr_en;
    logic        ctrl_wr;
    logic        dt_rise_wr;
    logic        dt_fall_wr;
    logic        en_reg;
    logic        hs_pol_reg;
    logic        ls_pol_reg;
    logic        fault_en_reg;
    logic        fault_flag_reg;
    logic        fault_flag_next;
    logic        fault_hit;
    logic        clear_req;
    logic [15:0] dt_rise_reg;
    logic [15:0] dt_rise_next;
    logic [15:0] dt_fall_reg;
    logic [15:0] dt_fall_next;

    // Upper byte lanes and upper data bits have no register behind them
    logic unused_bus;
    assign unused_bus = ^{be_i[3:2], wdata_i[31:16]};

    assign wr_en      = we_i & ~re_i;
    assign ctrl_wr    = wr_en & (addr_i == ADDR_CTRL) & be_i[0];
    assign dt_rise_wr = wr_en & (addr_i == ADDR_DT_RISE);
    assign dt_fall_wr = wr_en & (addr_i == ADDR_DT_FALL);

    // A clear request only counts once the synchronized fault has gone away
    assign clear_req  = ctrl_wr & wdata_i[4] & ~fault_s;
    assign fault_hit  = fault_en_reg & fault_s;

    assign fault_flag_next = fault_hit ? 1'b1 :
                             clear_req ? 1'b0 : fault_flag_reg;

    // Byte-lane merge for the two dead-time registers
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dt_lane
            assign dt_rise_next[gi*8 +: 8] = (dt_rise_wr && be_i[gi]) ?
                                             wdata_i[gi*8 +: 8] : dt_rise_reg[gi*8 +: 8];
            assign dt_fall_next[gi*8 +: 8] = (dt_fall_wr && be_i[gi]) ?
                                             wdata_i[gi*8 +: 8] : dt_fall_reg[gi*8 +: 8];
        end
    endgenerate

    // Configuration registers and the sticky fault flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_reg         <= 1'b0;
            hs_pol_reg     <= 1'b0;
            ls_pol_reg     <= 1'b0;
            fault_en_reg   <= 1'b0;
            fault_flag_reg <= 1'b0;
            dt_rise_reg    <= 16'd0;
            dt_fall_reg    <= 16'd0;
        end else begin
            if (ctrl_wr) begin
                en_reg       <= wdata_i[0];
                hs_pol_reg   <= wdata_i[1];
                ls_pol_reg   <= wdata_i[2];
                fault_en_reg <= wdata_i[3];
            end
            fault_flag_reg <= fault_flag_next;
            dt_rise_reg    <= dt_rise_next;
            dt_fall_reg    <= dt_fall_next;
        end
    end

    // ------------------------------------------------------------------
    // Dead-time FSM
    // ------------------------------------------------------------------
    state_t      state_reg;
    state_t      state_next;
    logic [15:0] cnt_reg;
    logic [15:0] cnt_next;
    logic        hs_o_reg;
    logic        ls_o_reg;
    logic        oe_o_reg;

    // State and dead-time counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 16'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state: fault first, then disable, then pwm edges; a zero dead
    // time bypasses the DT state entirely. A pwm reversal inside a DT state
    // wins over count expiry so a swallowed pulse never reaches the other side.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (fault_hit) begin
            state_next = ST_FAULT;
        end else if (state_reg == ST_FAULT) begin
            if (clear_req) begin
                state_next = ST_IDLE;
            end
        end else if (!en_reg) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_LS_ON, ST_HS_ON: begin
                    if (pwm_s && (state_reg != ST_HS_ON)) begin
                        if (dt_rise_reg == 16'd0) begin
                            state_next = ST_HS_ON;
                        end else begin
                            state_next = ST_DT_R;
                            cnt_next   = dt_rise_reg - 16'd1;
                        end
                    end else if (!pwm_s && (state_reg != ST_LS_ON)) begin
                        if (dt_fall_reg == 16'd0) begin
                            state_next = ST_LS_ON;
                        end else begin
                            state_next = ST_DT_F;
                            cnt_next   = dt_fall_reg - 16'd1;
                        end
                    end
                end
                ST_DT_R: begin
                    if (!pwm_s) begin
                        state_next = ST_LS_ON;
                    end else if (cnt_reg == 16'd0) begin
                        state_next = ST_HS_ON;
                    end else begin
                        cnt_next = cnt_reg - 16'd1;
                    end
                end
                ST_DT_F: begin
                    if (pwm_s) begin
                        state_next = ST_HS_ON;
                    end else if (cnt_reg == 16'd0) begin
                        state_next = ST_LS_ON;
                    end else begin
                        cnt_next = cnt_reg - 16'd1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Pin drivers decoded from the next state so they move with the state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs_o_reg <= 1'b0;
            ls_o_reg <= 1'b0;
            oe_o_reg <= 1'b0;
        end else begin
            hs_o_reg <= (state_next == ST_HS_ON) ^ hs_pol_reg;
            ls_o_reg <= (state_next == ST_LS_ON) ^ ls_pol_reg;
            oe_o_reg <= en_reg & (state_next != ST_FAULT);
        end
    end

    assign hs_o = hs_o_reg;
    assign ls_o = ls_o_reg;
    assign oe_o = oe_o_reg;

    // Combinational read mux, unmapped addresses return zero
    always_comb begin
        rdata_o = 32'd0;
        case (addr_i)
            ADDR_CTRL:    rdata_o = {27'd0, fault_flag_reg, fault_en_reg,
                                     ls_pol_reg, hs_pol_reg, en_reg};
            ADDR_DT_RISE: rdata_o = {16'd0, dt_rise_reg};
            ADDR_DT_FALL: rdata_o = {16'd0, dt_fall_reg};
            ADDR_STATUS:  rdata_o = {27'd0, fault_s, pwm_s, state_reg};
            default:      rdata_o = 32'd0;
        endcase
    end

endmodule
